// File: rtl/dmem_responder.sv
// Byte-addressed data memory responder with one-cycle registered reads and masked writes.
// Define DMEM_RESPONDER_FAULT_EN to compile in range and ren/wen conflict fault checking.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [31:0]   lin [4];
  logic [AW-1:0] idx [4];
  logic [31:0]   rd_word;
  logic          wr_act;
  logic          fault;
  logic          rd_acc;
  logic          wr_acc;

  // Each lane indexes independently so a word may straddle the top of the array and wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lin[k] = i_dmem_addr + 32'(k) - BASE_ADDR;
      idx[k] = lin[k][AW-1:0];
    end
    rd_word = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
    wr_act  = i_dmem_wen && (i_dmem_mask != 4'b0000);
  end

`ifdef DMEM_RESPONDER_FAULT_EN
  logic [33:0] byte_addr [4];
  logic [3:0]  oob;
  logic [3:0]  touched;

  // Range test is done on the unwrapped 34-bit address so nothing near 2^32 aliases back in.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = {2'b00, i_dmem_addr} + 34'(k);
      oob[k] = (byte_addr[k] < {2'b00, BASE_ADDR}) ||
               (byte_addr[k] >= ({2'b00, BASE_ADDR} + 34'(DEPTH_BYTES)));
    end
    touched = (i_dmem_ren ? 4'hF : 4'h0) | (wr_act ? i_dmem_mask : 4'h0);
    fault   = (|(oob & touched)) || (i_dmem_ren && wr_act);
  end
`else
  assign fault = 1'b0;
`endif

  assign rd_acc = i_dmem_ren && !fault;
  assign wr_acc = wr_act && !fault;

  // Array is never reset; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        if (i_dmem_mask[k]) begin
          mem[idx[k]] <= i_dmem_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dmem_rdata <= 32'h0;
      o_rd_count   <= 32'h0;
      o_wr_count   <= 32'h0;
    end else begin
      o_dmem_rdata <= rd_acc ? rd_word : 32'h0;
      if (rd_acc && (o_rd_count != 32'hFFFF_FFFF)) begin
        o_rd_count <= o_rd_count + 32'd1;
      end
      if (wr_acc && (o_wr_count != 32'hFFFF_FFFF)) begin
        o_wr_count <= o_wr_count + 32'd1;
      end
    end
  end

`ifdef DMEM_RESPONDER_FAULT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fault      <= 1'b0;
      o_fault_addr <= 32'h0;
    end else begin
      o_fault <= fault;
      if (fault) begin
        o_fault_addr <= i_dmem_addr;
      end
    end
  end
`else
  assign o_fault      = 1'b0;
  assign o_fault_addr = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, saturation sequence, and a randomized run
// against a byte-array reference model. Honours DMEM_RESPONDER_FAULT_EN like the design.
module tb_dmem_responder;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h0;
`ifdef DMEM_RESPONDER_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        fault;
  logic [31:0] fault_addr;

  dmem_responder #(
    .DEPTH_BYTES(Depth),
    .BASE_ADDR  (Base)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dmem_addr (addr),
    .i_dmem_ren  (ren),
    .i_dmem_wen  (wen),
    .i_dmem_wdata(wdata),
    .i_dmem_mask (mask),
    .o_dmem_rdata(rdata),
    .o_rd_count  (rd_count),
    .o_wr_count  (wr_count),
    .o_fault     (fault),
    .o_fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mm [Depth];
  logic [31:0] m_rdata, m_rd, m_wr, m_faddr;
  logic        m_fault;

  typedef struct {
    logic        rst, ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata, exp_rd, exp_wr;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [7:0] pat(input int unsigned a);
    return 8'(a ^ (a >> 3) ^ 32'h5A);
  endfunction

  function automatic vec_t mk(input logic r, input logic rn, input logic wn,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic [31:0] er, input logic [31:0] erc,
                              input logic [31:0] ewc);
    vec_t v;
    v.rst = r; v.ren = rn; v.wen = wn; v.addr = a; v.wdata = d; v.mask = m;
    v.exp_rdata = er; v.exp_rd = erc; v.exp_wr = ewc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned lane_idx(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k) - Base;
    return int'(s % Depth);
  endfunction

  task automatic model_step(input logic r, input logic rn, input logic wn,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic        flt;
    logic        wact;
    logic [33:0] ba;
    if (r) begin
      m_rdata = 0; m_rd = 0; m_wr = 0; m_fault = 0; m_faddr = 0;
      return;
    end
    wact = wn && (m != 4'b0);
    flt  = 1'b0;
    if (FaultEn) begin
      if (rn && wact) flt = 1'b1;
      for (int k = 0; k < 4; k++) begin
        ba = {2'b00, a} + 34'(k);
        if ((rn || (wact && m[k])) &&
            ((ba < {2'b00, Base}) || (ba >= {2'b00, Base} + 34'(Depth)))) flt = 1'b1;
      end
    end
    if (rn && !flt)
      m_rdata = {mm[lane_idx(a, 3)], mm[lane_idx(a, 2)], mm[lane_idx(a, 1)], mm[lane_idx(a, 0)]};
    else
      m_rdata = 32'h0;
    if (wact && !flt) begin
      for (int k = 0; k < 4; k++) if (m[k]) mm[lane_idx(a, k)] = d[8*k +: 8];
      if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
    end
    if (rn && !flt && (m_rd != 32'hFFFF_FFFF)) m_rd = m_rd + 1;
    m_fault = flt;
    if (flt) m_faddr = a;
  endtask

  task automatic drive(input logic r, input logic rn, input logic wn,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    rst = r; ren = rn; wen = wn; addr = a; wdata = d; mask = m;
    @(posedge clk);
    model_step(r, rn, wn, a, d, m);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_rd_count"}, rd_count, m_rd);
    check({tag, "_wr_count"}, wr_count, m_wr);
    check({tag, "_fault"}, 32'(fault), 32'(m_fault));
    check({tag, "_fault_addr"}, fault_addr, m_faddr);
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = 0; wdata = 0; mask = 0;
    m_rdata = 0; m_rd = 0; m_wr = 0; m_fault = 0; m_faddr = 0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rd_count", rd_count, 32'h0);
    check("reset_wr_count", wr_count, 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    check("reset_fault_addr", fault_addr, 32'h0);

    // Fill the whole array with a known pattern, then reset to clear counters only.
    for (int i = 0; i < int'(Depth / 4); i++) begin
      drive(0, 0, 1, 32'(4 * i),
            {pat(4 * i + 3), pat(4 * i + 2), pat(4 * i + 1), pat(4 * i)}, 4'hF);
    end
    check_model("after_fill");
    drive(1, 0, 0, 0, 0, 0);

`ifndef DMEM_RESPONDER_FAULT_EN
    tbl[0]  = mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1);
    tbl[2]  = mk(0, 0, 1, 32'h13, 32'h000000AA, 4'h1, 32'h0, 1, 2);
    tbl[3]  = mk(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hAAADBEEF, 2, 2);
    tbl[4]  = mk(0, 0, 1, 32'h20, 32'h11111111, 4'hF, 32'h0, 2, 3);
    tbl[5]  = mk(0, 1, 1, 32'h20, 32'h22222222, 4'hF, 32'h11111111, 3, 4);
    tbl[6]  = mk(0, 1, 0, 32'h20, 32'h0, 4'h0, 32'h22222222, 4, 4);
    tbl[7]  = mk(0, 0, 0, 32'h20, 32'h0, 4'h0, 32'h0, 4, 4);
    tbl[8]  = mk(0, 0, 1, 32'h30, 32'h12345678, 4'h0, 32'h0, 4, 4);
    tbl[9]  = mk(1, 0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
    tbl[10] = mk(0, 1, 0, 32'h30, 32'h0, 4'h0,
                 {pat(32'h33), pat(32'h32), pat(32'h31), pat(32'h30)}, 1, 0);
    tbl[11] = mk(0, 1, 0, 32'h3FE, 32'h0, 4'h0,
                 {pat(32'h1), pat(32'h0), pat(32'h3FF), pat(32'h3FE)}, 2, 0);
    tbl[12] = mk(0, 1, 0, 32'h410, 32'h0, 4'h0, 32'hAAADBEEF, 3, 0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("vec%0d_rd_count", i), rd_count, tbl[i].exp_rd);
      check($sformatf("vec%0d_wr_count", i), wr_count, tbl[i].exp_wr);
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'h0);
      check($sformatf("vec%0d_fault_addr", i), fault_addr, 32'h0);
    end
`else
    drive(0, 1, 0, 32'h3FE, 32'h0, 4'h0);
    check("oob_read_rdata", rdata, 32'h0);
    check("oob_read_fault", 32'(fault), 32'h1);
    check("oob_read_fault_addr", fault_addr, 32'h3FE);
    check("oob_read_rd_count", rd_count, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("fault_pulse_end", 32'(fault), 32'h0);
    check("fault_addr_hold", fault_addr, 32'h3FE);
    drive(0, 1, 1, 32'h10, 32'h55555555, 4'hF);
    check_model("rw_conflict");
    check("rw_conflict_fault", 32'(fault), 32'h1);
    drive(0, 0, 1, 32'h3FD, 32'h99999999, 4'hF);
    check_model("oob_write");
    drive(0, 0, 1, 32'h3FE, 32'h0000BBCC, 4'h3);
    check_model("edge_write_ok");
    drive(0, 1, 0, 32'h3FC, 32'h0, 4'h0);
    check("edge_read_rdata", rdata, {8'hBB, 8'hCC, pat(32'h3FD), pat(32'h3FC)});
    check_model("edge_read");
    drive(0, 1, 0, 32'h10, 32'h0, 4'h0);
    check_model("conflict_suppressed");
`endif

    // Saturation: preload the read counter just below the ceiling.
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; ren = 1'b0; wen = 1'b0;
    force dut.o_rd_count = 32'hFFFF_FFFE;
    #1;
    release dut.o_rd_count;
    m_rd = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h40, 32'h0, 4'h0);
      check($sformatf("sat_read%0d", i), rd_count, 32'hFFFF_FFFF);
    end
    check_model("sat_end");

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        r, rn, wn;
      logic [31:0] a;
      r  = ($urandom % 50) == 0;
      rn = $urandom % 2;
      wn = ($urandom % 3) == 0;
      a  = ($urandom % 4 != 0) ? 32'($urandom_range(0, Depth - 1)) : $urandom;
      drive(r, rn, wn, a, $urandom, 4'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
